// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
//   Shared definitions for the bit-serial adder controller.
//   Holds the controller state encoding so the top level and any future
//   sequencing consumers of the half-adder cells agree on the same values.
//   No ports (package).
package serial_add_ctrl_pkg;

  // Two-bit state encoding; 2'd3 is unused and treated as an illegal state
  // that the controller steers back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_slice.sv
// fa_slice
//   Combinational full-adder slice built from two half-adder cells and an OR.
//   The serial controller time-shares this single slice across every bit.
//   Ports:
//     a, b   in  1  operand bits
//     ci     in  1  carry in
//     s      out 1  sum bit
//     co     out 1  carry out
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c1;
  logic c2;

  ha_cell u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c1)
  );

  ha_cell u_ha1 (
    .a     (s0),
    .b     (ci),
    .sum   (s),
    .carry (c2)
  );

  // At most one of the two half-adder carries can be set, so OR is enough.
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl_ha_cell.sv
// ha_cell
//   Dataflow half-adder cell: one-bit sum and carry of two input bits.
//   Ports:
//     a, b   in  1  addend bits
//     sum    out 1  a ^ b
//     carry  out 1  a & b
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial WIDTH-bit adder controller. Captures operands on a start
//   handshake, pushes one bit per clock (LSB first) through a shared
//   full-adder slice, then returns sum/cout with a one-cycle done pulse.
//   Ports:
//     clk    in  1      rising-edge clock
//     rst    in  1      asynchronous active-high reset
//     start  in  1      request, accepted only while idle
//     a, b   in  WIDTH  operands, sampled on the accepting edge
//     cin    in  1      carry in, sampled on the accepting edge
//     busy   out 1      high while running or presenting the result
//     done   out 1      one-cycle pulse, sum/cout valid while high
//     sum    out WIDTH  result, held until the next accepted request
//     cout   out 1      carry out of the top bit, held with sum
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is wide enough to reach WIDTH so it never wraps inside a run.
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               slice_s;
  logic               slice_co;
  logic [WIDTH-1:0]   bit_mask;

  fa_slice u_slice (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // One-hot select of the sum bit being written this cycle; the other bits
  // keep their previous-result values until overwritten.
  assign bit_mask = WIDTH'(1) << cnt_q;

  // Next-state and datapath update. Everything holds by default; IDLE loads
  // the operands on start, RUN retires one bit per cycle through the slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~bit_mask) | ({WIDTH{slice_s}} & bit_mask);
        carry_d = slice_co;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = slice_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are decoded from the next state and registered, so the
    // outputs carry no combinational path from the inputs.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered output flops; reset clears everything,
  // which also aborts any add in progress without producing a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Scoreboard bench for serial_add_ctrl at WIDTH = 1, 8 and 13. Stimulus
//   pushes the model result {cout,sum} = a+b+cin into a per-instance queue;
//   a monitor per instance pops and compares whenever done is high.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        start1, a1, b1, cin1, busy1, done1, sum1, cout1;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int          n_compared   = 0;
  int          n_mismatched = 0;

  logic [64:0] sb1[$];
  logic [64:0] sb8[$];
  logic [64:0] sb13[$];
  logic [64:0] last1, last8, last13;

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [64:0] act,
                             input logic [64:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] resultOf(input int w);
    case (w)
      1:       return {63'b0, cout1, sum1};
      13:      return {51'b0, cout13, sum13};
      default: return {56'b0, cout8, sum8};
    endcase
  endfunction

  function automatic logic busyOf(input int w);
    case (w)
      1:       return busy1;
      13:      return busy13;
      default: return busy8;
    endcase
  endfunction

  function automatic logic doneOf(input int w);
    case (w)
      1:       return done1;
      13:      return done13;
      default: return done8;
    endcase
  endfunction

  function automatic logic [64:0] lastOf(input int w);
    case (w)
      1:       return last1;
      13:      return last13;
      default: return last8;
    endcase
  endfunction

  task automatic setStart(input int w, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic c);
    case (w)
      1:       begin start1  = v; a1  = a[0];    b1  = b[0];    cin1  = c; end
      13:      begin start13 = v; a13 = a[12:0]; b13 = b[12:0]; cin13 = c; end
      default: begin start8  = v; a8  = a[7:0];  b8  = b[7:0];  cin8  = c; end
    endcase
  endtask

  // Issue one request from a negedge; returns at the first negedge after
  // the accepting edge with the operands scrambled to prove single sampling.
  task automatic applyStimulus(input int w, input logic [63:0] a,
                               input logic [63:0] b, input logic c);
    logic [63:0] mask;
    logic [64:0] exp;
    int          guard;
    mask  = (64'd1 << w) - 64'd1;
    guard = 0;
    while (busyOf(w) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busyOf(w)) checkOutput("busy_wait_timeout", 65'(busyOf(w)), 65'd0);
    exp = 65'(a & mask) + 65'(b & mask) + 65'(c);
    case (w)
      1:       begin sb1.push_back(exp);  last1  = exp; end
      13:      begin sb13.push_back(exp); last13 = exp; end
      default: begin sb8.push_back(exp);  last8  = exp; end
    endcase
    setStart(w, 1'b1, a, b, c);
    @(negedge clk);
    setStart(w, 1'b0, ~a, ~b, ~c);
  endtask

  // Wait (bounded) for done, checking latency, busy span, pulse width and
  // that the result holds once back in idle.
  task automatic waitDone(input int w, input string tag);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    while (!doneOf(w) && lat < 200) begin
      if (busyOf(w)) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (busyOf(w)) busy_cnt++;
    checkOutput({tag, "_done_seen"},   65'(doneOf(w)), 65'd1);
    checkOutput({tag, "_latency"},     65'(lat),       65'(w));
    checkOutput({tag, "_busy_cycles"}, 65'(busy_cnt),  65'(w + 1));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"},  65'(doneOf(w)), 65'd0);
    checkOutput({tag, "_busy_idle"},   65'(busyOf(w)), 65'd0);
    checkOutput({tag, "_sum_hold"},    resultOf(w),    lastOf(w));
  endtask

  task automatic runOp(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input string tag);
    applyStimulus(w, a, b, c);
    waitDone(w, tag);
  endtask

  // Scoreboard monitors: one per instance, popping on every done pulse
  always @(negedge clk) begin
    if (!rst && done8) begin
      checkOutput("w8_done_expected", 65'(sb8.size() != 0), 65'd1);
      if (sb8.size() != 0) checkOutput("w8_result", resultOf(8), sb8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      checkOutput("w1_done_expected", 65'(sb1.size() != 0), 65'd1);
      if (sb1.size() != 0) checkOutput("w1_result", resultOf(1), sb1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && done13) begin
      checkOutput("w13_done_expected", 65'(sb13.size() != 0), 65'd1);
      if (sb13.size() != 0) checkOutput("w13_result", resultOf(13), sb13.pop_front());
    end
  end

  // Global watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    int guard;
    rst = 1'b1;
    setStart(1, 1'b0, 64'd0, 64'd0, 1'b0);
    setStart(8, 1'b0, 64'd0, 64'd0, 1'b0);
    setStart(13, 1'b0, 64'd0, 64'd0, 1'b0);
    last1 = '0; last8 = '0; last13 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy8",    65'(busy8), 65'd0);
    checkOutput("reset_done8",    65'(done8), 65'd0);
    checkOutput("reset_result8",  resultOf(8),  65'd0);
    checkOutput("reset_result13", resultOf(13), 65'd0);
    checkOutput("reset_result1",  resultOf(1),  65'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 vectors
    runOp(8, 64'h00, 64'h00, 1'b0, "t1_zero");
    runOp(8, 64'hFF, 64'h01, 1'b0, "t2_wrap");
    runOp(8, 64'hA5, 64'h5A, 1'b1, "t3_ripple");
    runOp(8, 64'h80, 64'h80, 1'b0, "msb_carry");
    runOp(8, 64'h7F, 64'h80, 1'b1, "mixed_carry");
    runOp(8, 64'h0F, 64'h0F, 1'b0, "nibble");

    // Starts during RUN and during DONE must be ignored
    applyStimulus(8, 64'h3C, 64'h0F, 1'b0);
    repeat (2) @(negedge clk);
    setStart(8, 1'b1, 64'hFF, 64'hFF, 1'b1);
    @(negedge clk);
    setStart(8, 1'b0, 64'h00, 64'h00, 1'b0);
    guard = 0;
    while (!done8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t4_done_seen", 65'(done8), 65'd1);
    setStart(8, 1'b1, 64'h01, 64'h01, 1'b0);
    @(negedge clk);
    setStart(8, 1'b0, 64'h00, 64'h00, 1'b0);
    checkOutput("t4_busy_after",   65'(busy8), 65'd0);
    checkOutput("t4_result_kept",  resultOf(8), 65'h04B);
    repeat (12) @(negedge clk);
    checkOutput("t4_still_idle",   65'(busy8), 65'd0);
    checkOutput("t4_result_final", resultOf(8), 65'h04B);

    // Reset in the middle of a run aborts it
    applyStimulus(8, 64'hAA, 64'h55, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_busy_rst",   65'(busy8), 65'd0);
    checkOutput("t5_done_rst",   65'(done8), 65'd0);
    checkOutput("t5_result_rst", resultOf(8), 65'd0);
    sb8.delete();
    last8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_idle_after", 65'(busy8), 65'd0);
    runOp(8, 64'h12, 64'h34, 1'b0, "t5_after");

    // WIDTH=1: every input combination
    for (int i = 0; i < 8; i++) begin
      runOp(1, 64'(i & 1), 64'((i >> 1) & 1), 1'((i >> 2) & 1), "w1");
    end

    // Random sweeps at WIDTH=8 and WIDTH=13
    for (int i = 0; i < 1000; i++) begin
      runOp(8, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      runOp(13, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), "rnd13");
    end

    repeat (5) @(negedge clk);
    checkOutput("sb8_drained",  65'(sb8.size()),  65'd0);
    checkOutput("sb1_drained",  65'(sb1.size()),  65'd0);
    checkOutput("sb13_drained", 65'(sb13.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
